// File: rtl/sdram_pkg.sv
// Shared SDRAM init definitions: command encodings, error codes, mode-register
// field positions and the monitor's state and command-kind types.
package sdram_pkg;

    localparam logic [3:0] CMD_MRS = 4'b0000;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_NOP = 4'b0111;

    localparam logic [2:0] ERR_NONE        = 3'd0;
    localparam logic [2:0] ERR_EARLY       = 3'd1;
    localparam logic [2:0] ERR_ORDER       = 3'd2;
    localparam logic [2:0] ERR_TIMING      = 3'd3;
    localparam logic [2:0] ERR_PRE_NOT_ALL = 3'd4;
    localparam logic [2:0] ERR_BAD_MODE    = 3'd5;
    localparam logic [2:0] ERR_FEW_REFRESH = 3'd6;

    localparam int MODE_BL_LSB  = 0;
    localparam int MODE_BT_BIT  = 3;
    localparam int MODE_CAS_LSB = 4;
    localparam int MODE_WB_BIT  = 9;
    localparam int ADDR_AP_BIT  = 10;

    localparam logic [11:0] MODE_DEFAULT = 12'h032;

    typedef enum logic [2:0] {
        ST_WAIT_PWR,
        ST_WAIT_PRE,
        ST_PRECHARGED,
        ST_REFRESHING,
        ST_MRS_WAIT,
        ST_DONE,
        ST_ERROR
    } state_t;

    typedef enum logic [2:0] {
        K_NOP,
        K_PRE,
        K_REF,
        K_MRS,
        K_OTHER
    } cmd_kind_t;

    // cs high deselects the device, so it is a NOP whatever the other bits are.
    function automatic cmd_kind_t decode_cmd(input logic [3:0] cmd);
        cmd_kind_t k;
        if (cmd[3]) begin
            k = K_NOP;
        end else begin
            case (cmd)
                CMD_NOP: k = K_NOP;
                CMD_PRE: k = K_PRE;
                CMD_REF: k = K_REF;
                CMD_MRS: k = K_MRS;
                default: k = K_OTHER;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/sdram_mode_decode.sv
// Splits a 12-bit mode-register word into its fields and flags combinations
// the attached SDRAM does not support.
module sdram_mode_decode
    import sdram_pkg::*;
(
    input  logic [11:0] i_mode,
    output logic [2:0]  o_bl,
    output logic        o_bt,
    output logic [2:0]  o_cas,
    output logic        o_wb,
    output logic        o_legal
);

    logic w_unused_bits;

    assign o_bl  = i_mode[MODE_BL_LSB +: 3];
    assign o_bt  = i_mode[MODE_BT_BIT];
    assign o_cas = i_mode[MODE_CAS_LSB +: 3];
    assign o_wb  = i_mode[MODE_WB_BIT];
    assign w_unused_bits = ^{i_mode[11:10], i_mode[8:7]};

    // Full-page burst (BL=7) only exists for sequential bursts.
    always_comb begin
        o_legal = 1'b1;
        if (o_cas != 3'd2 && o_cas != 3'd3) o_legal = 1'b0;
        if (o_bl == 3'd4 || o_bl == 3'd5 || o_bl == 3'd6) o_legal = 1'b0;
        if (o_bl == 3'd7 && o_bt) o_legal = 1'b0;
    end

endmodule

// File: rtl/sdram_init_monitor.sv
// Device-side checker for the SDRAM power-up init sequence: tracks init state,
// enforces command gaps, latches the mode register and reports done/first error.
module sdram_init_monitor
    import sdram_pkg::*;
#(
    parameter int FREQUENCY   = 50,
    parameter int INI_TIME    = 200,
    parameter int TRP_CYC     = 1,
    parameter int TRFC_CYC    = 4,
    parameter int TMRD_CYC    = 2,
    parameter int MIN_REFRESH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_cmd,
    input  logic [11:0] i_sdram_addr,
    output logic        o_init_done,
    output logic        o_err,
    output logic [2:0]  o_err_code,
    output logic [2:0]  o_mode_bl,
    output logic        o_mode_bt,
    output logic [2:0]  o_mode_cas,
    output logic        o_mode_wb,
    output logic [3:0]  o_refresh_cnt
);

    localparam int         WAIT_CNT = FREQUENCY * INI_TIME;
    localparam logic [15:0] PWR_LAST = 16'(WAIT_CNT - 1);
    localparam logic [3:0]  TRP4     = 4'(TRP_CYC);
    localparam logic [3:0]  TRFC4    = 4'(TRFC_CYC);
    localparam logic [3:0]  TMRD4    = 4'(TMRD_CYC);
    localparam logic [3:0]  MINREF4  = 4'(MIN_REFRESH);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_pwr_cnt;
    logic [3:0]  r_gap;
    logic        r_last_ref;
    logic [3:0]  r_refresh_cnt;
    logic        r_err;
    logic [2:0]  r_err_code;
    logic        r_init_done;
    logic [2:0]  r_mode_bl;
    logic        r_mode_bt;
    logic [2:0]  r_mode_cas;
    logic        r_mode_wb;

    cmd_kind_t   w_kind;
    logic        w_ap;
    logic [3:0]  w_min_gap;
    logic        w_err;
    logic [2:0]  w_code;
    logic        w_accept;
    logic        w_latch_mode;
    logic [2:0]  w_bl;
    logic        w_bt;
    logic [2:0]  w_cas;
    logic        w_wb;
    logic        w_mode_legal;

    sdram_mode_decode u_mode_decode (
        .i_mode  (i_sdram_addr),
        .o_bl    (w_bl),
        .o_bt    (w_bt),
        .o_cas   (w_cas),
        .o_wb    (w_wb),
        .o_legal (w_mode_legal)
    );

    assign w_kind    = decode_cmd(i_cmd);
    assign w_ap      = i_sdram_addr[ADDR_AP_BIT];
    assign w_min_gap = r_last_ref ? TRFC4 : TRP4;
    assign w_latch_mode = (r_state == ST_PRECHARGED || r_state == ST_REFRESHING)
                          && (w_kind == K_MRS);

    always_ff @(posedge i_clk) begin
        if (!i_rst) r_state <= ST_WAIT_PWR;
        else        r_state <= w_state_nxt;
    end

    // Check order inside each state encodes the error priority.
    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_code      = ERR_NONE;
        w_accept    = 1'b0;
        case (r_state)
            ST_WAIT_PWR: begin
                if (w_kind != K_NOP) begin
                    w_err  = 1'b1;
                    w_code = ERR_EARLY;
                end else if (r_pwr_cnt == PWR_LAST) begin
                    w_state_nxt = ST_WAIT_PRE;
                end
            end
            ST_WAIT_PRE: begin
                if (w_kind == K_PRE && w_ap) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_PRECHARGED;
                end else if (w_kind == K_PRE) begin
                    w_err  = 1'b1;
                    w_code = ERR_PRE_NOT_ALL;
                end else if (w_kind != K_NOP) begin
                    w_err  = 1'b1;
                    w_code = ERR_ORDER;
                end
            end
            ST_PRECHARGED, ST_REFRESHING: begin
                if (w_kind == K_OTHER) begin
                    w_err  = 1'b1;
                    w_code = ERR_ORDER;
                end else if (w_kind == K_MRS && r_refresh_cnt < MINREF4) begin
                    w_err  = 1'b1;
                    w_code = ERR_FEW_REFRESH;
                end else if (w_kind == K_PRE && !w_ap) begin
                    w_err  = 1'b1;
                    w_code = ERR_PRE_NOT_ALL;
                end else if (w_kind != K_NOP && r_gap < w_min_gap) begin
                    w_err  = 1'b1;
                    w_code = ERR_TIMING;
                end else if (w_kind == K_MRS && !w_mode_legal) begin
                    w_err  = 1'b1;
                    w_code = ERR_BAD_MODE;
                end else if (w_kind != K_NOP) begin
                    w_accept = 1'b1;
                    if (w_kind == K_REF) w_state_nxt = ST_REFRESHING;
                    if (w_kind == K_MRS) w_state_nxt = ST_MRS_WAIT;
                end
            end
            ST_MRS_WAIT: begin
                if (r_gap >= TMRD4) begin
                    w_state_nxt = ST_DONE;
                end else if (w_kind != K_NOP) begin
                    w_err  = 1'b1;
                    w_code = ERR_TIMING;
                end
            end
            default: ;
        endcase
        if (w_err) w_state_nxt = ST_ERROR;
    end

    // Gap is loaded with 1 on an accepted command so that its value at the next
    // command equals the number of cycles between the two issues.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_pwr_cnt     <= '0;
            r_gap         <= '0;
            r_last_ref    <= 1'b0;
            r_refresh_cnt <= '0;
            r_err         <= 1'b0;
            r_err_code    <= ERR_NONE;
            r_init_done   <= 1'b0;
            r_mode_bl     <= '0;
            r_mode_bt     <= 1'b0;
            r_mode_cas    <= '0;
            r_mode_wb     <= 1'b0;
        end else begin
            if (r_state == ST_WAIT_PWR && r_pwr_cnt != PWR_LAST)
                r_pwr_cnt <= r_pwr_cnt + 16'd1;
            if (w_accept) begin
                r_gap      <= 4'd1;
                r_last_ref <= (w_kind == K_REF);
            end else if (r_gap != 4'hF) begin
                r_gap <= r_gap + 4'd1;
            end
            if (w_accept && w_kind == K_REF && r_refresh_cnt != 4'hF)
                r_refresh_cnt <= r_refresh_cnt + 4'd1;
            if (w_latch_mode) begin
                r_mode_bl  <= w_bl;
                r_mode_bt  <= w_bt;
                r_mode_cas <= w_cas;
                r_mode_wb  <= w_wb;
            end
            if (w_err) begin
                r_err      <= 1'b1;
                r_err_code <= w_code;
            end
            r_init_done <= (w_state_nxt == ST_DONE);
        end
    end

    assign o_init_done   = r_init_done;
    assign o_err         = r_err;
    assign o_err_code    = r_err_code;
    assign o_mode_bl     = r_mode_bl;
    assign o_mode_bt     = r_mode_bt;
    assign o_mode_cas    = r_mode_cas;
    assign o_mode_wb     = r_mode_wb;
    assign o_refresh_cnt = r_refresh_cnt;

endmodule

// File: tb/tb_sdram_init_monitor.sv
// Bench for sdram_init_monitor: directed init sequences plus randomized ones,
// checked every cycle against a history-replay model of the init rules.
module tb_sdram_init_monitor;

    localparam int TB_FREQ = 50;
    localparam int TB_INI  = 2;
    localparam int W       = TB_FREQ * TB_INI;
    localparam int TRP     = 1;
    localparam int TRFC    = 4;
    localparam int TMRD    = 2;
    localparam int MINREF  = 2;
    localparam int SCH     = 256;

    localparam logic [3:0] C_MRS = 4'b0000;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_NOP = 4'b0111;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [3:0]  i_cmd;
    logic [11:0] i_sdram_addr;
    logic        o_init_done, o_err, o_mode_bt, o_mode_wb;
    logic [2:0]  o_err_code, o_mode_bl, o_mode_cas;
    logic [3:0]  o_refresh_cnt;

    sdram_init_monitor #(
        .FREQUENCY(TB_FREQ), .INI_TIME(TB_INI), .TRP_CYC(TRP),
        .TRFC_CYC(TRFC), .TMRD_CYC(TMRD), .MIN_REFRESH(MINREF)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cmd(i_cmd), .i_sdram_addr(i_sdram_addr),
        .o_init_done(o_init_done), .o_err(o_err), .o_err_code(o_err_code),
        .o_mode_bl(o_mode_bl), .o_mode_bt(o_mode_bt), .o_mode_cas(o_mode_cas),
        .o_mode_wb(o_mode_wb), .o_refresh_cnt(o_refresh_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        int         cyc;
        logic [3:0] c;
        logic [11:0] a;
    } ev_t;

    typedef struct {
        bit done;
        bit err;
        int code;
        int bl, bt, cas, wb, nref;
    } exp_t;

    ev_t  hist[$];
    int   m_cyc = 0;
    bit   m_started = 0;
    int   n_checks = 0;
    int   n_err = 0;
    exp_t m_exp;

    logic [3:0]  cmd_at  [SCH];
    logic [11:0] addr_at [SCH];

    function automatic bit mode_ok(input logic [11:0] a);
        int bl, cas;
        bl  = int'(a[2:0]);
        cas = int'(a[6:4]);
        if (!(cas == 2 || cas == 3)) return 0;
        if (bl <= 3) return 1;
        return (bl == 7) && !a[3];
    endfunction

    // Replays every non-NOP command since reset and states what the outputs
    // must be after the edge of cycle n.
    function automatic exp_t model(input int n);
        exp_t e;
        ev_t  v;
        int   last, gap, code, mrs;
        bit   last_ref, open;
        e = '{default: 0};
        last = -100; last_ref = 0; open = 0; mrs = -1;
        foreach (hist[k]) begin
            v = hist[k];
            if (v.cyc > n || e.err) break;
            code = 0;
            if (mrs >= 0) begin
                if (v.cyc - mrs >= TMRD) break;
                code = 3;
            end else if (v.cyc < W) begin
                code = 1;
            end else if (!open) begin
                if (v.c == C_PRE) code = v.a[10] ? 0 : 4;
                else              code = 2;
            end else begin
                gap = (v.cyc - last > 15) ? 15 : v.cyc - last;
                if (v.c != C_PRE && v.c != C_REF && v.c != C_MRS) code = 2;
                else if (v.c == C_MRS && e.nref < MINREF)          code = 6;
                else if (v.c == C_PRE && !v.a[10])                 code = 4;
                else if (gap < (last_ref ? TRFC : TRP))            code = 3;
                else if (v.c == C_MRS && !mode_ok(v.a))            code = 5;
                if (v.c == C_MRS) begin
                    e.bl  = int'(v.a[2:0]);
                    e.bt  = int'(v.a[3]);
                    e.cas = int'(v.a[6:4]);
                    e.wb  = int'(v.a[9]);
                end
            end
            if (code != 0) begin
                e.err  = 1;
                e.code = code;
            end else begin
                last     = v.cyc;
                last_ref = (v.c == C_REF);
                open     = 1;
                if (v.c == C_REF && e.nref < 15) e.nref++;
                if (v.c == C_MRS) mrs = v.cyc;
            end
        end
        e.done = (mrs >= 0) && !e.err && (n - mrs >= TMRD);
        return e;
    endfunction

    always @(posedge i_clk) begin
        m_started = 1;
        if (!i_rst) begin
            hist.delete();
            m_cyc = 0;
        end else begin
            if (!i_cmd[3] && i_cmd != C_NOP)
                hist.push_back('{m_cyc, i_cmd, i_sdram_addr});
            m_cyc++;
        end
    end

    always @(negedge i_clk) begin
        logic [16:0] act, expv;
        if (m_started) begin
            m_exp = model(m_cyc - 1);
            act  = {o_init_done, o_err, o_err_code, o_mode_bl, o_mode_bt,
                    o_mode_cas, o_mode_wb, o_refresh_cnt};
            expv = {m_exp.done, m_exp.err, 3'(m_exp.code), 3'(m_exp.bl), 1'(m_exp.bt),
                    3'(m_exp.cas), 1'(m_exp.wb), 4'(m_exp.nref)};
            n_checks++;
            if (act !== expv) begin
                n_err++;
                $display("FAIL cycle_outputs cyc=%0d got done/err/code/bl/bt/cas/wb/ref=%b/%b/%0d/%0d/%b/%0d/%b/%0d need %b/%b/%0d/%0d/%b/%0d/%b/%0d",
                         m_cyc - 1, o_init_done, o_err, o_err_code, o_mode_bl, o_mode_bt,
                         o_mode_cas, o_mode_wb, o_refresh_cnt, m_exp.done, m_exp.err,
                         m_exp.code, m_exp.bl, m_exp.bt, m_exp.cas, m_exp.wb, m_exp.nref);
            end
        end
    end

    // Pins both the DUT and the model to a hand-derived value.
    task automatic pin(input string name, input int dut_v, input int mdl_v, input int lit);
        n_checks += 2;
        if (dut_v != lit) begin
            n_err++;
            $display("FAIL %s dut got %0d need %0d", name, dut_v, lit);
        end
        if (mdl_v != lit) begin
            n_err++;
            $display("FAIL %s model got %0d need %0d", name, mdl_v, lit);
        end
    endtask

    task automatic clear_sched(input bit noisy);
        for (int c = 0; c < SCH; c++) begin
            addr_at[c] = 12'($urandom);
            if (noisy && $urandom_range(0, 3) == 0) cmd_at[c] = {1'b1, 3'($urandom)};
            else                                   cmd_at[c] = C_NOP;
        end
    endtask

    task automatic put(input int c, input logic [3:0] cmd, input logic [11:0] a);
        cmd_at[c]  = cmd;
        addr_at[c] = a;
    endtask

    task automatic legal_sched();
        clear_sched(0);
        put(W,     C_PRE, 12'h400);
        put(W + 1, C_REF, 12'h000);
        put(W + 5, C_REF, 12'h000);
        put(W + 9, C_MRS, sdram_pkg::MODE_DEFAULT);
    endtask

    task automatic run_case(input int len);
        i_rst = 1'b0;
        i_cmd = C_NOP;
        i_sdram_addr = '0;
        repeat (2) @(negedge i_clk);
        for (int c = 0; c < len; c++) begin
            i_rst        = 1'b1;
            i_cmd        = cmd_at[c];
            i_sdram_addr = addr_at[c];
            @(negedge i_clk);
        end
        i_cmd = C_NOP;
        m_exp = model(m_cyc - 1);
    endtask

    task automatic random_sched();
        int t, nref;
        clear_sched(1);
        t = W - 1 + $urandom_range(0, 3);
        put(t, C_PRE, ($urandom_range(0, 9) == 0) ? 12'h000 : (12'h400 | (12'($urandom) & 12'hBFF)));
        nref = $urandom_range(1, 3);
        for (int i = 0; i < nref; i++) begin
            t += ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 6);
            put(t, C_REF, 12'($urandom));
        end
        if ($urandom_range(0, 4) == 0) begin
            t += $urandom_range(1, 5);
            put(t, C_PRE, 12'h400);
        end
        t += $urandom_range(2, 6);
        put(t, C_MRS, ($urandom_range(0, 1) == 0) ? sdram_pkg::MODE_DEFAULT : 12'($urandom));
        if ($urandom_range(0, 2) == 0) begin
            t += $urandom_range(1, 3);
            put(t, 4'($urandom_range(0, 6)), 12'($urandom));
        end
        if ($urandom_range(0, 7) == 0)
            put(W + $urandom_range(0, 20), 4'b0100, 12'h000);
    endtask

    initial begin
        clear_sched(0);

        legal_sched();
        run_case(W + 11);
        pin("done_before_tmrd", o_init_done, m_exp.done, 0);
        run_case(W + 12);
        pin("legal_done", o_init_done, m_exp.done, 1);
        pin("legal_err", o_err, m_exp.err, 0);
        pin("legal_bl", o_mode_bl, m_exp.bl, 2);
        pin("legal_cas", o_mode_cas, m_exp.cas, 3);
        pin("legal_bt", o_mode_bt, m_exp.bt, 0);
        pin("legal_refcnt", o_refresh_cnt, m_exp.nref, 2);

        legal_sched();
        put(W - 1, C_PRE, 12'h400);
        run_case(W + 20);
        pin("early_code", o_err_code, m_exp.code, 1);
        pin("early_done", o_init_done, m_exp.done, 0);

        legal_sched();
        put(W + 5, C_NOP, 12'h000);
        put(W + 3, C_REF, 12'h000);
        run_case(W + 15);
        pin("trfc_code", o_err_code, m_exp.code, 3);

        clear_sched(0);
        put(W,     C_PRE, 12'h400);
        put(W + 1, C_REF, 12'h000);
        put(W + 5, C_MRS, sdram_pkg::MODE_DEFAULT);
        run_case(W + 10);
        pin("few_ref_code", o_err_code, m_exp.code, 6);

        legal_sched();
        put(W, C_PRE, 12'h000);
        run_case(W + 10);
        pin("pre_not_all_code", o_err_code, m_exp.code, 4);

        legal_sched();
        put(W + 9, C_MRS, 12'h052);
        run_case(W + 15);
        pin("bad_mode_code", o_err_code, m_exp.code, 5);
        pin("bad_mode_cas", o_mode_cas, m_exp.cas, 5);
        pin("bad_mode_done", o_init_done, m_exp.done, 0);

        legal_sched();
        run_case(W + 6);
        run_case(W + 15);
        pin("restart_done", o_init_done, m_exp.done, 1);
        pin("restart_refcnt", o_refresh_cnt, m_exp.nref, 2);

        for (int r = 0; r < 30; r++) begin
            random_sched();
            run_case(W + 45);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
